regfile_wb_buffer: RTL and testbench
====================================

// Module: regfile_wb_buffer
// PURPOSE
//  Write-back buffer and port arbiter in front of the 64x16 register file. Queues result writes
//  from the execute stage (valid/ready) and drains one per cycle into the register file write port.
//  Schedules operand reads from decode, which share the file's single cs/re/we port.
//  The file never sees re and we high together. A read never returns a value older than a queued write.
// PARAMETERS
//  WIDTH      64  data width; matches register file WIDTH
//  SELECT     4   register index width; matches register file SELECT
//  QDEPTH     4   write queue entries (power of 2, >=2)
//  MAX_DEFER  8   max consecutive cycles a non-empty queue may be denied a drain
// PORTS
//  clock             in   1       single clock, rising edge
//  reset             in   1       synchronous, active-high
//  wr_valid          in   1       execute presents a write
//  wr_ready          out  1       buffer accepts; = (count < QDEPTH)
//  wr_reg            in   SELECT  destination register
//  wr_data           in   WIDTH   write data
//  rd_req            in   1       decode requests an operand read
//  rd_ready          out  1       read granted this cycle
//  rd_reg1, rd_reg2  in   SELECT  source registers
//  rd_valid          out  1       read data valid (1 cycle after grant)
//  rd_data1, rd_data2 out WIDTH   registered read data
//  rf_cs, rf_re, rf_we out 1      register file controls
//  rf_read_reg1/2    out  SELECT  register file read indices (= rd_reg1/2)
//  rf_write_register out  SELECT  queue head index
//  rf_write_data     out  WIDTH   queue head data
//  rf_read_data1/2   in   WIDTH   register file combinational read data
//  pending           out  $clog2(QDEPTH)+1  queued write count
// BEHAVIOUR
//  Reset: queue empty, count=0, defer_cnt=0. wr_ready=1, rd_ready=0, rd_valid=0, rd_data*=0.
//   All rf_* controls 0. Reset mid-operation discards queued writes.
//  Push: wr_valid&wr_ready appends at tail. When full, wr_ready=0; a same-cycle drain does not raise it.
//  Per-cycle decision, exactly one of GRANT_READ / DRAIN / IDLE:
//   force = (count==QDEPTH) | (count!=0 & defer_cnt==MAX_DEFER) | hazard
//   hazard = rd_req & any valid entry matches rd_reg1 or rd_reg2 (no-bypass build only)
//   rd_req & !force          -> GRANT_READ: rf_cs=1, rf_re=1, rf_we=0, rd_ready=1
//   count!=0 & (!rd_req|force) -> DRAIN: rf_cs=1, rf_we=1, rf_re=0; head popped at edge
//   else                     -> IDLE: rf_cs=rf_re=rf_we=0
//  defer_cnt: +1 on GRANT_READ with count!=0; cleared on DRAIN or count==0; saturates at MAX_DEFER.
//  Read latency 1: on GRANT_READ, rd_data1/2 <= rf_read_data1/2 (or bypass); rd_valid=1 next cycle.
//  Same-cycle push and drain: count unchanged. Push into empty queue is not drainable that cycle.
//  Duplicate destinations drain in order (oldest first); last write wins in the file.
//  Pointers wrap modulo QDEPTH. count in 0..QDEPTH.
// CONFIGURATION
//  RF_WB_BYPASS_EN defined:
//   hazard term removed; reads are granted despite matching queued writes.
//   Each rd_data takes the youngest matching queue entry (push in same cycle excluded), else the file.
//  Not defined:
//   a matching queued write forces drains until no match remains; then the read is granted.
// STRUCTURE
//  Package regfile_pkg: WIDTH, SELECT constants; typedef wb_entry_t {reg idx, data}; arb state enum.
//  Sub-module regfile_wb_fifo: QDEPTH circular queue with head, count, and per-entry view for
//   match and bypass. The top level holds the arbiter, defer_cnt and read-data registers.
// TESTING
//  1 Reset: hold reset 2 cycles mid-queue (count=3). After: pending=0, rd_valid=0, rf_we=0.
//  2 Drain: push r3=0xA, r5=0xB, no reads. rf_we=1 two consecutive cycles; file r3=0xA, r5=0xB.
//  3 Full: push 4 while rd_req=1 on unrelated regs. Then wr_ready=0 and rd_ready=0.
//     One DRAIN occurs, and wr_ready=1 on the next cycle.
//  4 Starvation: count=1, rd_req=1 continuously on unrelated regs.
//     Exactly 8 grants, then a forced DRAIN; defer_cnt returns to 0.
//  5 Hazard, no bypass: queue r7=0x55, request r7. rd_ready=0 until drained.
//     The next grant returns rd_data1=0x55, one cycle later.
//  6 Bypass (RF_WB_BYPASS_EN): queue r2=1 then r2=2, request r2.
//     Granted immediately; rd_data1=2 next cycle. rf_re and rf_we are never both 1.

Source files
------------

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared constants and types for the register-file write-back buffer.
// Latency: n/a (types only).
// Backpressure: n/a.
package regfile_pkg;

  // Register file geometry: 16 registers of 64 bits.
  localparam int WIDTH  = 64;
  localparam int SELECT = 4;

  // One queued result write.
  typedef struct packed {
    logic [SELECT-1:0] idx;
    logic [WIDTH-1:0]  data;
  } wb_entry_t;

  // Per-cycle use of the shared register file port.
  typedef enum logic [1:0] {
    ARB_IDLE  = 2'd0,
    ARB_GRANT = 2'd1,
    ARB_DRAIN = 2'd2
  } arb_state_e;

endpackage

// File: rtl/regfile_wb_fifo.sv
// regfile_wb_fifo: circular queue of pending register writes.
// Latency: a push is visible (count, head, age view) the cycle after it is accepted.
// Backpressure: none internally; the caller must not push when full or pop when empty.
//
// Ports:
//   clock_i, reset_i      clock, synchronous active-high reset (empties the queue)
//   push_i, push_entry_i  append an entry at the tail
//   pop_i                 remove the head entry
//   count_o               number of queued entries, 0..QDEPTH
//   head_o                oldest entry
//   age_entry_o/age_vld_o entries in age order, [0] = oldest; valid bit per slot
module regfile_wb_fifo
  import regfile_pkg::*;
#(
  parameter int QDEPTH = 4
) (
  input  logic                      clock_i,
  input  logic                      reset_i,
  input  logic                      push_i,
  input  wb_entry_t                 push_entry_i,
  input  logic                      pop_i,
  output logic [$clog2(QDEPTH):0]   count_o,
  output wb_entry_t                 head_o,
  output wb_entry_t [QDEPTH-1:0]    age_entry_o,
  output logic [QDEPTH-1:0]         age_vld_o
);

  localparam int PW = $clog2(QDEPTH);

  wb_entry_t     mem_q [QDEPTH];
  logic [PW-1:0] head_q, head_d;
  logic [PW-1:0] tail_q, tail_d;
  logic [PW:0]   count_q, count_d;

  // Pointers are exactly PW bits wide, so increments wrap modulo QDEPTH.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    if (push_i) tail_d = tail_q + 1'b1;
    if (pop_i)  head_d = head_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
    end
  end

  // Storage carries no reset; slots are qualified by count.
  always_ff @(posedge clock_i) begin
    if (push_i) mem_q[tail_q] <= push_entry_i;
  end

  // Age-ordered view: slot k is the k-th oldest entry, valid while k < count.
  always_comb begin
    for (int k = 0; k < QDEPTH; k++) begin
      age_entry_o[k] = mem_q[head_q + PW'(k)];
      age_vld_o[k]   = ((PW+1)'(k) < count_q);
    end
  end

  assign count_o = count_q;
  assign head_o  = mem_q[head_q];

endmodule

// File: rtl/regfile_wb_buffer.sv
// regfile_wb_buffer: write-back queue and single-port arbiter in front of the 16x64 register file.
// Latency: read data 1 cycle after grant; a queued write drains no earlier than the cycle after its push.
// Backpressure: wr_ready_o low while the queue is full; rd_ready_o low whenever the port drains instead.
//
// Optional feature macro: RF_WB_BYPASS_EN. When defined, reads that hit a queued write are granted
// and served from the youngest matching queue entry. When undefined, such reads wait while the
// queue drains until no matching entry remains.
//
// Ports:
//   clock_i, reset_i                 clock, synchronous active-high reset
//   wr_valid_i/wr_ready_o            execute-stage write handshake (wr_reg_i, wr_data_i)
//   rd_req_i/rd_ready_o              decode-stage read request / grant (rd_reg1_i, rd_reg2_i)
//   rd_valid_o, rd_data1_o/2_o       registered read result, one cycle after grant
//   rf_cs_o, rf_re_o, rf_we_o        register file port controls (re and we are never both high)
//   rf_read_reg1_o/2_o               register file read indices
//   rf_write_register_o/data_o       queue head presented to the file write port
//   rf_read_data1_i/2_i              register file combinational read data
//   pending_o                        queued write count
module regfile_wb_buffer
  import regfile_pkg::*;
#(
  parameter int QDEPTH    = 4,
  parameter int MAX_DEFER = 8
) (
  input  logic                     clock_i,
  input  logic                     reset_i,
  input  logic                     wr_valid_i,
  output logic                     wr_ready_o,
  input  logic [SELECT-1:0]        wr_reg_i,
  input  logic [WIDTH-1:0]         wr_data_i,
  input  logic                     rd_req_i,
  output logic                     rd_ready_o,
  input  logic [SELECT-1:0]        rd_reg1_i,
  input  logic [SELECT-1:0]        rd_reg2_i,
  output logic                     rd_valid_o,
  output logic [WIDTH-1:0]         rd_data1_o,
  output logic [WIDTH-1:0]         rd_data2_o,
  output logic                     rf_cs_o,
  output logic                     rf_re_o,
  output logic                     rf_we_o,
  output logic [SELECT-1:0]        rf_read_reg1_o,
  output logic [SELECT-1:0]        rf_read_reg2_o,
  output logic [SELECT-1:0]        rf_write_register_o,
  output logic [WIDTH-1:0]         rf_write_data_o,
  input  logic [WIDTH-1:0]         rf_read_data1_i,
  input  logic [WIDTH-1:0]         rf_read_data2_i,
  output logic [$clog2(QDEPTH):0]  pending_o
);

  localparam int CW = $clog2(QDEPTH) + 1;
  localparam int DW = $clog2(MAX_DEFER + 1);

  logic [CW-1:0]          count;
  wb_entry_t              head;
  wb_entry_t [QDEPTH-1:0] age_entry;
  logic [QDEPTH-1:0]      age_vld;
  wb_entry_t              push_entry;
  logic                   push, pop;
  logic                   q_full, q_nonempty, starved, hazard, force_drain;
  arb_state_e             arb;

  logic [DW-1:0]          defer_q, defer_d;
  logic                   rd_valid_q;
  logic [WIDTH-1:0]       rd_data1_q, rd_data2_q;
  logic [WIDTH-1:0]       rd_src1, rd_src2;

  assign push_entry = '{idx: wr_reg_i, data: wr_data_i};

  regfile_wb_fifo #(.QDEPTH(QDEPTH)) u_fifo (
    .clock_i      (clock_i),
    .reset_i      (reset_i),
    .push_i       (push),
    .push_entry_i (push_entry),
    .pop_i        (pop),
    .count_o      (count),
    .head_o       (head),
    .age_entry_o  (age_entry),
    .age_vld_o    (age_vld)
  );

  assign q_full     = (count == CW'(QDEPTH));
  assign q_nonempty = (count != '0);
  assign starved    = q_nonempty && (defer_q == DW'(MAX_DEFER));

  // Ready depends only on the registered count, so a drain in the full
  // cycle does not reopen the queue until the next cycle.
  assign wr_ready_o = !q_full;
  assign push       = wr_valid_i && wr_ready_o;

`ifdef RF_WB_BYPASS_EN
  assign hazard = 1'b0;
`else
  // A read touching any queued destination must wait for that write to land.
  always_comb begin
    hazard = 1'b0;
    for (int k = 0; k < QDEPTH; k++) begin
      if (age_vld[k] && (age_entry[k].idx == rd_reg1_i || age_entry[k].idx == rd_reg2_i))
        hazard = 1'b1;
    end
    hazard = hazard && rd_req_i;
  end
`endif

  assign force_drain = q_full || starved || hazard;

  always_comb begin
    arb = ARB_IDLE;
    if (reset_i)                      arb = ARB_IDLE;
    else if (rd_req_i && !force_drain) arb = ARB_GRANT;
    else if (q_nonempty)              arb = ARB_DRAIN;
  end

  assign pop                 = (arb == ARB_DRAIN);
  assign rd_ready_o          = (arb == ARB_GRANT);
  assign rf_re_o             = (arb == ARB_GRANT);
  assign rf_we_o             = (arb == ARB_DRAIN);
  assign rf_cs_o             = rf_re_o || rf_we_o;
  assign rf_read_reg1_o      = rd_reg1_i;
  assign rf_read_reg2_o      = rd_reg2_i;
  assign rf_write_register_o = head.idx;
  assign rf_write_data_o     = head.data;
  assign pending_o           = count;

  // Counts reads granted while writes wait; an empty queue or a drain clears it.
  always_comb begin
    defer_d = defer_q;
    if (pop || !q_nonempty)
      defer_d = '0;
    else if (arb == ARB_GRANT && defer_q != DW'(MAX_DEFER))
      defer_d = defer_q + 1'b1;
  end

  // Read source: the file, or in the bypass build the youngest queued match
  // (ascending age scan, so later matches overwrite earlier ones).
  always_comb begin
    rd_src1 = rf_read_data1_i;
    rd_src2 = rf_read_data2_i;
`ifdef RF_WB_BYPASS_EN
    for (int k = 0; k < QDEPTH; k++) begin
      if (age_vld[k] && age_entry[k].idx == rd_reg1_i) rd_src1 = age_entry[k].data;
      if (age_vld[k] && age_entry[k].idx == rd_reg2_i) rd_src2 = age_entry[k].data;
    end
`endif
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      defer_q    <= '0;
      rd_valid_q <= 1'b0;
      rd_data1_q <= '0;
      rd_data2_q <= '0;
    end else begin
      defer_q    <= defer_d;
      rd_valid_q <= (arb == ARB_GRANT);
      if (arb == ARB_GRANT) begin
        rd_data1_q <= rd_src1;
        rd_data2_q <= rd_src2;
      end
    end
  end

  assign rd_valid_o = rd_valid_q;
  assign rd_data1_o = rd_data1_q;
  assign rd_data2_o = rd_data2_q;

endmodule

// File: tb/tb_regfile_wb_buffer.sv
// tb_regfile_wb_buffer: directed bench for the write-back buffer with a behavioural register file.
// Latency: checks combinational outputs mid-cycle and registered read data one cycle after grant.
// Backpressure: exercises full-queue stall, forced drains, starvation limit and read hazards.
module tb_regfile_wb_buffer;
  import regfile_pkg::*;

  logic              clock = 1'b0;
  logic              reset;
  logic              wr_valid, wr_ready;
  logic [SELECT-1:0] wr_reg;
  logic [WIDTH-1:0]  wr_data;
  logic              rd_req, rd_ready;
  logic [SELECT-1:0] rd_reg1, rd_reg2;
  logic              rd_valid;
  logic [WIDTH-1:0]  rd_data1, rd_data2;
  logic              rf_cs, rf_re, rf_we;
  logic [SELECT-1:0] rf_read_reg1, rf_read_reg2, rf_write_register;
  logic [WIDTH-1:0]  rf_write_data, rf_read_data1, rf_read_data2;
  logic [2:0]        pending;

  always #5 clock = ~clock;

  regfile_wb_buffer #(.QDEPTH(4), .MAX_DEFER(8)) dut (
    .clock_i             (clock),
    .reset_i             (reset),
    .wr_valid_i          (wr_valid),
    .wr_ready_o          (wr_ready),
    .wr_reg_i            (wr_reg),
    .wr_data_i           (wr_data),
    .rd_req_i            (rd_req),
    .rd_ready_o          (rd_ready),
    .rd_reg1_i           (rd_reg1),
    .rd_reg2_i           (rd_reg2),
    .rd_valid_o          (rd_valid),
    .rd_data1_o          (rd_data1),
    .rd_data2_o          (rd_data2),
    .rf_cs_o             (rf_cs),
    .rf_re_o             (rf_re),
    .rf_we_o             (rf_we),
    .rf_read_reg1_o      (rf_read_reg1),
    .rf_read_reg2_o      (rf_read_reg2),
    .rf_write_register_o (rf_write_register),
    .rf_write_data_o     (rf_write_data),
    .rf_read_data1_i     (rf_read_data1),
    .rf_read_data2_i     (rf_read_data2),
    .pending_o           (pending)
  );

  // Behavioural register file: reset loads 0x1000+index into every register.
  logic [WIDTH-1:0] rf_mem [16];
  always @(posedge clock) begin
    if (reset) begin
      for (int i = 0; i < 16; i++) rf_mem[i] <= 64'h1000 + 64'(i);
    end else if (rf_we) begin
      rf_mem[rf_write_register] <= rf_write_data;
    end
  end
  assign rf_read_data1 = rf_mem[rf_read_reg1];
  assign rf_read_data2 = rf_mem[rf_read_reg2];

  int n_assert = 0;
  int n_fail   = 0;
  int both_hi  = 0;

  always @(negedge clock) if (rf_re && rf_we) both_hi++;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int  grants;
  logic drained;

  initial begin
    reset = 1'b1; wr_valid = 1'b0; wr_reg = '0; wr_data = '0;
    rd_req = 1'b0; rd_reg1 = '0; rd_reg2 = '0;

    // Power-on reset
    cyc(); cyc();
    reset = 1'b0;
    #1;
    chk("rst pending",  64'(pending),  64'd0);
    chk("rst wr_ready", 64'(wr_ready), 64'd1);
    chk("rst rd_ready", 64'(rd_ready), 64'd0);
    chk("rst rd_valid", 64'(rd_valid), 64'd0);
    chk("rst rd_data1", rd_data1,      64'd0);
    chk("rst rf_cs",    64'(rf_cs),    64'd0);
    cyc();

    // 1: build count=3 behind unrelated reads, then reset mid-queue
    rd_req = 1'b1; rd_reg1 = 4'd10; rd_reg2 = 4'd11;
    for (int i = 1; i <= 3; i++) begin
      wr_valid = 1'b1; wr_reg = SELECT'(i); wr_data = 64'h10 + 64'(i);
      #1;
      chk("t1 grant while filling", 64'(rd_ready), 64'd1);
      cyc();
    end
    wr_valid = 1'b0;
    #1;
    chk("t1 pending before reset", 64'(pending), 64'd3);
    reset = 1'b1;
    cyc(); cyc();
    reset = 1'b0; rd_req = 1'b0;
    #1;
    chk("t1 pending after reset",  64'(pending),  64'd0);
    chk("t1 rd_valid after reset", 64'(rd_valid), 64'd0);
    chk("t1 rf_we after reset",    64'(rf_we),    64'd0);
    chk("t1 wr_ready after reset", 64'(wr_ready), 64'd1);
    cyc();

    // 2: two writes drain on consecutive cycles
    wr_valid = 1'b1; wr_reg = 4'd3; wr_data = 64'hA;
    #1;
    chk("t2 no drain on push into empty", 64'(rf_we), 64'd0);
    cyc();
    wr_reg = 4'd5; wr_data = 64'hB;
    #1;
    chk("t2 drain1 we",  64'(rf_we),             64'd1);
    chk("t2 drain1 reg", 64'(rf_write_register), 64'd3);
    chk("t2 pending",    64'(pending),           64'd1);
    cyc();
    wr_valid = 1'b0;
    #1;
    chk("t2 drain2 we",   64'(rf_we),             64'd1);
    chk("t2 drain2 reg",  64'(rf_write_register), 64'd5);
    chk("t2 drain2 data", rf_write_data,          64'hB);
    cyc();
    #1;
    chk("t2 idle we",  64'(rf_we), 64'd0);
    chk("t2 file r3",  rf_mem[3],  64'hA);
    chk("t2 file r5",  rf_mem[5],  64'hB);
    cyc();

    // 3: fill the queue while reads on unrelated registers are granted
    rd_req = 1'b1; rd_reg1 = 4'd10; rd_reg2 = 4'd11;
    for (int i = 0; i < 4; i++) begin
      wr_valid = 1'b1; wr_reg = SELECT'(12 + i); wr_data = 64'hC0 + 64'(i);
      #1;
      chk("t3 grant while filling", 64'(rd_ready), 64'd1);
      cyc();
    end
    wr_reg = 4'd9; wr_data = 64'h99;
    #1;
    chk("t3 full pending",   64'(pending),           64'd4);
    chk("t3 full wr_ready",  64'(wr_ready),          64'd0);
    chk("t3 full rd_ready",  64'(rd_ready),          64'd0);
    chk("t3 forced drain",   64'(rf_we),             64'd1);
    chk("t3 drain head reg", 64'(rf_write_register), 64'd12);
    chk("t3 prior read vld", 64'(rd_valid),          64'd1);
    chk("t3 prior read dat", rd_data1,               64'h100A);
    cyc();
    #1;
    chk("t3 wr_ready reopens", 64'(wr_ready), 64'd1);
    chk("t3 grant after drain", 64'(rd_ready), 64'd1);
    chk("t3 pending after drain", 64'(pending), 64'd3);
    cyc();
    wr_valid = 1'b0; rd_req = 1'b0;
    #1;
    for (int i = 0; i < 10 && pending != 0; i++) cyc();
    chk("t3 all drained", 64'(pending), 64'd0);
    chk("t3 file r12",    rf_mem[12],   64'hC0);
    chk("t3 file r15",    rf_mem[15],   64'hC3);
    chk("t3 file r9",     rf_mem[9],    64'h99);
    cyc();

    // 4: starvation limit, twice to show the defer count restarts
    rd_req = 1'b1; rd_reg1 = 4'd10; rd_reg2 = 4'd11;
    for (int rep = 0; rep < 2; rep++) begin
      wr_valid = 1'b1; wr_reg = 4'd6; wr_data = 64'h60 + 64'(rep);
      #1;
      cyc();
      wr_valid = 1'b0;
      grants = 0; drained = 1'b0;
      for (int i = 0; i < 20 && !drained; i++) begin
        #1;
        if (rf_we) drained = 1'b1;
        else begin
          if (rd_ready) grants++;
          cyc();
        end
      end
      chk("t4 forced drain seen", 64'(drained), 64'd1);
      chk("t4 grants before drain", 64'(grants), 64'd8);
      cyc();
      #1;
      chk("t4 pending after drain", 64'(pending), 64'd0);
      chk("t4 file r6", rf_mem[6], 64'h60 + 64'(rep));
    end
    rd_req = 1'b0;
    cyc();

`ifndef RF_WB_BYPASS_EN
    // 5: read of a queued destination waits for the drain
    rd_req = 1'b1; rd_reg1 = 4'd10; rd_reg2 = 4'd11;
    wr_valid = 1'b1; wr_reg = 4'd7; wr_data = 64'h55;
    #1;
    chk("t5 unrelated grant", 64'(rd_ready), 64'd1);
    cyc();
    wr_valid = 1'b0; rd_reg1 = 4'd7;
    #1;
    chk("t5 hazard blocks read", 64'(rd_ready),          64'd0);
    chk("t5 hazard drains",      64'(rf_we),             64'd1);
    chk("t5 hazard drain reg",   64'(rf_write_register), 64'd7);
    cyc();
    #1;
    chk("t5 grant after drain", 64'(rd_ready), 64'd1);
    chk("t5 pending",           64'(pending),  64'd0);
    cyc();
    rd_req = 1'b0;
    #1;
    chk("t5 rd_valid", 64'(rd_valid), 64'd1);
    chk("t5 rd_data1", rd_data1,      64'h55);
    chk("t5 rd_data2", rd_data2,      64'h100B);
    cyc();
`else
    // 6: bypass returns the youngest queued write
    rd_req = 1'b1; rd_reg1 = 4'd10; rd_reg2 = 4'd11;
    wr_valid = 1'b1; wr_reg = 4'd2; wr_data = 64'd1;
    #1;
    cyc();
    wr_data = 64'd2;
    #1;
    cyc();
    wr_valid = 1'b0; rd_reg1 = 4'd2; rd_reg2 = 4'd10;
    #1;
    chk("t6 immediate grant", 64'(rd_ready), 64'd1);
    chk("t6 no drain",        64'(rf_we),    64'd0);
    chk("t6 pending",         64'(pending),  64'd2);
    cyc();
    rd_req = 1'b0;
    #1;
    chk("t6 rd_valid", 64'(rd_valid), 64'd1);
    chk("t6 rd_data1", rd_data1,      64'd2);
    chk("t6 rd_data2", rd_data2,      64'h100A);
    for (int i = 0; i < 10 && pending != 0; i++) cyc();
    chk("t6 file r2", rf_mem[2], 64'd2);
    cyc();
`endif

    chk("re and we never both high", 64'(both_hi), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
